// File: rtl/decoder_scan_sequencer.sv
// Select generator for a 3-to-8 decoder: walks 0..7 or 7..0 with a programmable dwell.
// Runs as a continuous scan or as a single sweep. All outputs are registered.
//
//   state | meaning
//   IDLE  | sel parked at 0, sel_valid/busy low, waiting for start
//   RUN   | sel stepping every TICK_DIV cycles in the latched direction
module decoder_scan_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic       dir,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       busy,
    output logic       sweep_done
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          mode_q, mode_nxt;
    logic          dir_q, dir_nxt;
    logic [2:0]    sel_nxt;
    logic          sel_valid_nxt, busy_nxt, sweep_done_nxt;
    logic [2:0]    sel_last;
    logic [2:0]    sel_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            mode_q     <= 1'b0;
            dir_q      <= 1'b0;
            sel        <= 3'd0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            mode_q     <= mode_nxt;
            dir_q      <= dir_nxt;
            sel        <= sel_nxt;
            sel_valid  <= sel_valid_nxt;
            busy       <= busy_nxt;
            sweep_done <= sweep_done_nxt;
        end
    end

    always_comb begin
        sel_last = dir_q ? 3'd0 : 3'd7;
        sel_step = dir_q ? (sel - 3'd1) : (sel + 3'd1);
    end

    always_comb begin
        state_nxt      = state;
        presc_nxt      = presc;
        mode_nxt       = mode_q;
        dir_nxt        = dir_q;
        sel_nxt        = sel;
        sel_valid_nxt  = sel_valid;
        busy_nxt       = busy;
        sweep_done_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                sel_nxt       = 3'd0;
                sel_valid_nxt = 1'b0;
                busy_nxt      = 1'b0;
                presc_nxt     = '0;
                if (start) begin
                    state_nxt     = RUN;
                    mode_nxt      = mode;
                    dir_nxt       = dir;
                    sel_nxt       = dir ? 3'd7 : 3'd0;
                    sel_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                end
            end
            RUN: begin
                sel_valid_nxt = 1'b1;
                busy_nxt      = 1'b1;
                // stop outranks a coincident sweep end, so no completion pulse
                if (stop) begin
                    state_nxt     = IDLE;
                    presc_nxt     = '0;
                    sel_nxt       = 3'd0;
                    sel_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                end else if (presc == PRESC_LAST) begin
                    presc_nxt = '0;
                    sel_nxt   = sel_step;
                    if (sel == sel_last) begin
                        sweep_done_nxt = 1'b1;
                        if (mode_q) begin
                            state_nxt     = IDLE;
                            sel_nxt       = 3'd0;
                            sel_valid_nxt = 1'b0;
                            busy_nxt      = 1'b0;
                        end
                    end
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: a TICK_DIV=4 and a TICK_DIV=1 instance checked each
// cycle against an elapsed-time model, plus a behavioural 3-to-8 decoder on each select.
module tb_decoder_scan_sequencer;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       start_v = '0;
    logic [1:0]       stop_v = '0;
    logic [1:0]       mode_v = '0;
    logic [1:0]       dir_v = '0;
    logic [1:0][2:0]  sel_v;
    logic [1:0]       valid_v;
    logic [1:0]       busy_v;
    logic [1:0]       done_v;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int   td [2] = '{4, 1};
    bit   m_run [2];
    int   m_n [2];
    bit   m_mode [2];
    bit   m_dir [2];
    int   exp_sel [2];
    bit   exp_valid [2];
    bit   exp_done [2];

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]),
        .mode(mode_v[0]), .dir(dir_v[0]), .sel(sel_v[0]), .sel_valid(valid_v[0]),
        .busy(busy_v[0]), .sweep_done(done_v[0])
    );

    decoder_scan_sequencer #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]),
        .mode(mode_v[1]), .dir(dir_v[1]), .sel(sel_v[1]), .sel_valid(valid_v[1]),
        .busy(busy_v[1]), .sweep_done(done_v[1])
    );

    // n counts edges since the start edge; sel follows from n/dwell alone
    task automatic model_update(input int i);
        int pos;
        exp_done[i] = 1'b0;
        if (!rst_n) begin
            m_run[i] = 1'b0;
        end else if (!m_run[i]) begin
            if (start_v[i]) begin
                m_run[i]  = 1'b1;
                m_n[i]    = 0;
                m_mode[i] = mode_v[i];
                m_dir[i]  = dir_v[i];
            end
        end else if (stop_v[i]) begin
            m_run[i] = 1'b0;
        end else begin
            m_n[i]++;
            if (m_n[i] % (8 * td[i]) == 0) begin
                exp_done[i] = 1'b1;
                if (m_mode[i]) m_run[i] = 1'b0;
            end
        end
        if (m_run[i]) begin
            pos          = (m_n[i] / td[i]) % 8;
            exp_sel[i]   = m_dir[i] ? 7 - pos : pos;
            exp_valid[i] = 1'b1;
        end else begin
            exp_sel[i]   = 0;
            exp_valid[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [7:0] dec, dec_exp;
        for (int i = 0; i < 2; i++) begin
            dec     = valid_v[i] ? (8'b1 << sel_v[i]) : 8'b0;
            dec_exp = exp_valid[i] ? (8'b1 << exp_sel[i]) : 8'b0;
            vectors += 5;
            assert (sel_v[i] === 3'(exp_sel[i])) else begin
                miscompares++;
                $error("FAIL sel[%0d] t=%0t got %0d exp %0d", i, $time, sel_v[i], exp_sel[i]);
            end
            assert (valid_v[i] === exp_valid[i]) else begin
                miscompares++;
                $error("FAIL sel_valid[%0d] t=%0t got %0b exp %0b", i, $time, valid_v[i], exp_valid[i]);
            end
            assert (busy_v[i] === exp_valid[i]) else begin
                miscompares++;
                $error("FAIL busy[%0d] t=%0t got %0b exp %0b", i, $time, busy_v[i], exp_valid[i]);
            end
            assert (done_v[i] === exp_done[i]) else begin
                miscompares++;
                $error("FAIL sweep_done[%0d] t=%0t got %0b exp %0b", i, $time, done_v[i], exp_done[i]);
            end
            assert (dec === dec_exp) else begin
                miscompares++;
                $error("FAIL decode[%0d] t=%0t got %b exp %b", i, $time, dec, dec_exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_all();
    endtask

    task automatic pulse_start(input int i, input bit md, input bit dr);
        mode_v[i]  = md;
        dir_v[i]   = dr;
        start_v[i] = 1'b1;
        step();
        start_v[i] = 1'b0;
    endtask

    task automatic pulse_stop(input int i);
        stop_v[i] = 1'b1;
        step();
        stop_v[i] = 1'b0;
    endtask

    task automatic run_until_sel(input int i, input int target);
        int budget = 200;
        while (exp_sel[i] != target && budget > 0) begin
            step();
            budget--;
        end
        vectors++;
        assert (budget > 0) else begin
            miscompares++;
            $error("FAIL wait_sel[%0d] got timeout exp sel=%0d", i, target);
        end
    endtask

    task automatic run_until_n(input int i, input int target);
        int budget = 200;
        while (m_n[i] != target && budget > 0) begin
            step();
            budget--;
        end
        vectors++;
        assert (budget > 0) else begin
            miscompares++;
            $error("FAIL wait_n[%0d] got timeout exp n=%0d", i, target);
        end
    endtask

    initial begin
        // reset state
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // continuous up scan, two full sweeps
        pulse_start(0, 1'b0, 1'b0);
        repeat (70) step();
        pulse_stop(0);

        // single sweep down, then confirm it stays parked
        pulse_start(0, 1'b1, 1'b1);
        repeat (40) step();

        // stop mid-scan, then stop exactly on the sweep-end edge
        pulse_start(0, 1'b0, 1'b0);
        run_until_sel(0, 3);
        pulse_stop(0);
        repeat (5) step();
        pulse_start(0, 1'b0, 1'b0);
        run_until_n(0, 31);
        pulse_stop(0);
        repeat (5) step();

        // reset mid-run, then a fresh start
        pulse_start(0, 1'b0, 1'b0);
        run_until_sel(0, 5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        pulse_start(0, 1'b0, 1'b0);
        repeat (10) step();
        pulse_stop(0);

        // single-cycle dwell; input changes and start during RUN are ignored
        pulse_start(1, 1'b0, 1'b0);
        repeat (12) step();
        mode_v[1]  = 1'b1;
        dir_v[1]   = 1'b1;
        start_v[1] = 1'b1;
        repeat (4) step();
        start_v[1] = 1'b0;
        repeat (20) step();
        pulse_stop(1);

        // start and stop together in IDLE: start wins
        start_v[0] = 1'b1;
        stop_v[0]  = 1'b1;
        step();
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b0;
        repeat (6) step();
        pulse_stop(0);

        // randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                start_v[i] = ($urandom_range(0, 7) == 0);
                stop_v[i]  = ($urandom_range(0, 39) == 0);
                mode_v[i]  = 1'($urandom_range(0, 1));
                dir_v[i]   = 1'($urandom_range(0, 1));
            end
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n   = 1'b1;
        start_v = '0;
        stop_v  = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
